// File: rtl/noise_pkg.sv
// Shared types, defaults and the shift/saturate helper for the noise serializer.
package noise_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned SHIFT_W   = 5;

  // Wide enough for any supported input width (32 or 48) after sign extension.
  localparam int unsigned SAMPLE_W  = 64;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX_DEF = (64'sd1 <<< (OUT_W_DEF - 1)) - 64'sd1;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN_DEF = ~SAT_MAX_DEF;

  // Largest representable value of a signed out_w-bit sample.
  function automatic logic signed [SAMPLE_W-1:0] sat_max(input int unsigned out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  // Smallest representable value of a signed out_w-bit sample.
  function automatic logic signed [SAMPLE_W-1:0] sat_min(input int unsigned out_w);
    return ~sat_max(out_w);
  endfunction

  // Arithmetic right shift then clamp to the signed out_w-bit range.
  // The caller sign-extends to SAMPLE_W, so shifts at or beyond the
  // original input width naturally collapse to 0 or -1.
  function automatic logic signed [SAMPLE_W-1:0] sat_shift(
    input logic signed [SAMPLE_W-1:0] sample,
    input logic        [SHIFT_W-1:0]  shift,
    input int unsigned                out_w
  );
    logic signed [SAMPLE_W-1:0] s;
    logic signed [SAMPLE_W-1:0] hi;
    logic signed [SAMPLE_W-1:0] lo;
    s  = sample >>> shift;
    hi = sat_max(out_w);
    lo = sat_min(out_w);
    if (s > hi) begin
      return hi;
    end
    if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/noise_serializer_if.sv
// Pair-in / sample-out stream bundle between the Box-Muller core and its consumer.
interface noise_serializer_if #(
  parameter int unsigned IN_W  = noise_pkg::IN_W_DEF,
  parameter int unsigned OUT_W = noise_pkg::OUT_W_DEF,
  parameter int unsigned CNT_W = noise_pkg::CNT_W_DEF
);

  logic                          in_valid;
  logic [IN_W-1:0]               n1;
  logic [IN_W-1:0]               n2;
  logic                          in_ready;
  logic [noise_pkg::SHIFT_W-1:0] shift;
  logic                          out_valid;
  logic                          out_ready;
  logic [OUT_W-1:0]              out_data;
  logic                          out_sel;
  logic [CNT_W-1:0]              drop_cnt;

  // Generator/consumer side.
  modport master (
    output in_valid, n1, n2, shift, out_ready,
    input  in_ready, out_valid, out_data, out_sel, drop_cnt
  );

  // Serializer side.
  modport slave (
    input  in_valid, n1, n2, shift, out_ready,
    output in_ready, out_valid, out_data, out_sel, drop_cnt
  );

endinterface

// File: rtl/pair_fifo.sv
// Small synchronous FIFO of sample pairs; storage is deliberately not reset.
module pair_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come only from the registered count.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; power-of-two depth lets pointers wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/noise_serializer.sv
// Buffers Gaussian sample pairs and streams them out one scaled, saturated sample at a time.
module noise_serializer
  import noise_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  noise_serializer_if.slave io
);

  localparam int unsigned PAIR_W = 2 * IN_W;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    sample_acc;
  logic                    drop;
  logic                    out_sel_q;
  logic [CNT_W-1:0]        drop_q;
  logic [PAIR_W-1:0]       head;
  logic signed [IN_W-1:0]  half;

  // n1 sits in the upper half of each stored entry.
  pair_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({io.n1, io.n2}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push       = io.in_valid && !fifo_full;
  assign drop       = io.in_valid && fifo_full;
  assign sample_acc = !fifo_empty && io.out_ready;
  assign pop        = sample_acc && out_sel_q;

  // Half-select: toggles per accepted sample, so it returns to 0 on every pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel_q <= 1'b0;
    end else if (sample_acc) begin
      out_sel_q <= !out_sel_q;
    end
  end

  // Saturating count of pairs lost while the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  always_comb begin
    half = '0;
    if (out_sel_q) begin
      half = head[IN_W-1:0];
    end else begin
      half = head[PAIR_W-1:IN_W];
    end
  end

  assign io.in_ready  = !fifo_full;
  assign io.out_valid = !fifo_empty;
  assign io.out_sel   = out_sel_q;
  assign io.drop_cnt  = drop_q;
  assign io.out_data  = fifo_empty ? '0
                                   : OUT_W'(sat_shift(SAMPLE_W'(half), io.shift, OUT_W));

endmodule

// File: tb/tb_noise_serializer.sv
// Scoreboard bench for noise_serializer: directed pairs in, monitor checks every accepted sample.
module tb_noise_serializer;
  import noise_pkg::*;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noise_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  noise_serializer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               m_cnt    = 0;
  logic             m_sel    = 1'b0;
  int               m_drop   = 0;
  logic             m_known  = 1'b0;
  logic [OUT_W-1:0] e1;
  logic [OUT_W-1:0] e2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check state against the model, advance the model, cross the edge.
  task automatic tick();
    logic push;
    logic pop_s;
    logic pop_p;
    @(negedge clk);
    if (m_known) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_cnt != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(m_cnt != 0));
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
      if (m_cnt == 0) begin
        chk("idle_data", 32'(bus.out_data), 32'h0);
        chk("idle_sel", 32'(bus.out_sel), 32'h0);
      end
    end
    if (rst) begin
      m_cnt   = 0;
      m_sel   = 1'b0;
      m_drop  = 0;
      m_known = 1'b1;
      sb.delete();
    end else begin
      push  = bus.in_valid && (m_cnt != DEPTH);
      pop_s = bus.out_ready && (m_cnt != 0);
      pop_p = pop_s && m_sel;
      if (push) begin
        sb.push_back('{data: e1, sel: 1'b0});
        sb.push_back('{data: e2, sel: 1'b1});
      end
      if (bus.in_valid && !push && (m_drop < 65535)) m_drop++;
      m_cnt = m_cnt + (push ? 1 : 0) - (pop_p ? 1 : 0);
      if (pop_s) m_sel = !m_sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                            input logic [OUT_W-1:0] ea, input logic [OUT_W-1:0] eb);
    bus.in_valid = 1'b1;
    bus.n1       = a;
    bus.n2       = b;
    e1           = ea;
    e2           = eb;
  endtask

  task automatic drain(input int max_cycles, input string name);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0) && (n < max_cycles)) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'h0);
  endtask

  // Monitor: every accepted sample must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1)) begin
        if (sb.size() == 0) begin
          chk("unexpected_sample", 32'(bus.out_data), 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.data));
          chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned      sh_tab [3];
    logic [OUT_W-1:0] sat_e1 [3];
    logic [OUT_W-1:0] sat_e2 [3];
    int               low_ready;

    sh_tab = '{0, 16, 31};
    sat_e1 = '{16'h7FFF, 16'h7FFF, 16'h0000};
    sat_e2 = '{16'h8000, 16'h8000, 16'hFFFF};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.n1        = '0;
    bus.n2        = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b0;
    e1            = '0;
    e2            = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);

    // Single pair, no scaling.
    bus.out_ready = 1'b1;
    drive_pair(32'h0000_1234, 32'hFFFF_FF00, 16'h1234, 16'hFF00);
    tick();
    bus.in_valid = 1'b0;
    drain(10, "single");
    chk("single_valid_after", 32'(bus.out_valid), 32'h0);
    chk("single_drop", 32'(bus.drop_cnt), 32'h0);

    // Saturation and large shifts.
    for (int k = 0; k < 3; k++) begin
      bus.shift = SHIFT_W'(sh_tab[k]);
      drive_pair(32'h7FFF_FFFF, 32'h8000_0000, sat_e1[k], sat_e2[k]);
      tick();
      bus.in_valid = 1'b0;
      drain(10, "sat");
    end
    bus.shift = '0;

    // Fill and overflow with the consumer stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_pair(32'(i * 256 + 17), 32'(-(i + 1)), 16'(i * 256 + 17), 16'(-(i + 1)));
      tick();
      if (i == 3) chk("fill_in_ready_low", 32'(bus.in_ready), 32'h0);
    end
    bus.in_valid = 1'b0;
    chk("fill_drop_cnt", 32'(bus.drop_cnt), 32'h2);
    drain(20, "fill");
    chk("fill_drop_kept", 32'(bus.drop_cnt), 32'h2);

    // Consumer stalls between n1 and n2 of a pair.
    bus.out_ready = 1'b0;
    drive_pair(32'h0000_0ABC, 32'hFFFF_F543, 16'h0ABC, 16'hF543);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", 32'(bus.out_data), 32'h0000_F543);
      chk("hold_sel", 32'(bus.out_sel), 32'h1);
      chk("hold_valid", 32'(bus.out_valid), 32'h1);
    end
    drain(10, "hold");

    // Back-to-back: generator every cycle, consumer always ready.
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    low_ready     = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready == 1'b0) low_ready++;
      drive_pair(32'(i * 37 - 1000), 32'(500 - i * 53), 16'(i * 37 - 1000), 16'(500 - i * 53));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b_drop_cnt", 32'(bus.drop_cnt), 32'd47);
    chk("b2b_drop_vs_ready", 32'(bus.drop_cnt), 32'(low_ready));
    drain(20, "b2b");

    // Reset in the middle of a half-consumed pair.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'(i + 1), 32'(i + 101), 16'(i + 1), 16'(i + 101));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("mid_sel_before_rst", 32'(bus.out_sel), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'h0);
    bus.out_ready = 1'b1;
    drive_pair(32'h0000_0055, 32'hFFFF_FFAA, 16'h0055, 16'hFFAA);
    tick();
    bus.in_valid = 1'b0;
    drain(10, "post_rst");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noise_serializer.md
# noise_serializer

Downstream stage of the Box-Muller Gaussian noise generator. Each cycle it can accept one pair of signed Gaussian samples from the generator's two multiplier outputs and holds them in a small pair FIFO. It emits the samples one at a time, n1 first and then n2, on a valid/ready stream. Each sample is scaled by an arithmetic right shift and saturated to the output width. The generator free-runs with no backpressure, so pairs that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- IN_W, 32: width of each input sample; matches the generator output width (32 or 48).
- OUT_W, 16: width of the output sample, OUT_W ≤ IN_W.
- DEPTH, 4: FIFO depth in pairs, power of two, ≥ 2.
- CNT_W, 16: width of the drop counter.

Ports:
- clk, in, 1: single clock, all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: a sample pair is present on n1/n2 this cycle.
- n1, in, IN_W: first sample, signed two's complement (sin branch).
- n2, in, IN_W: second sample, signed two's complement (cos branch).
- in_ready, out, 1: FIFO not full; a pair presented now will be stored.
- shift, in, 5: arithmetic right-shift amount (sigma scaling); hold stable while out_valid=1.
- out_valid, out, 1: out_data holds a valid sample.
- out_ready, in, 1: consumer accepts out_data this cycle.
- out_data, out, OUT_W: scaled, saturated signed sample.
- out_sel, out, 1: 0 means out_data comes from n1, 1 means it comes from n2.
- drop_cnt, out, CNT_W: number of dropped pairs, saturating.

## Operation
- Storage: DEPTH entries of {n1,n2}, 2·IN_W bits each.
  - Write pointer, read pointer, and count register (0..DEPTH) are all registered.
  - Pointers wrap modulo DEPTH.
- Push: happens when in_valid && in_ready.
  - in_ready = (count != DEPTH), taken from registered state only.
  - When count = DEPTH, no push occurs, even if a pop happens in the same cycle.
- Drop: when in_valid && !in_ready, drop_cnt increments.
  - drop_cnt saturates at 2^CNT_W−1 and never wraps.
- Output: out_valid = (count != 0).
  - out_sel is a registered half-select bit.
  - The selected half of the head entry is shifted and saturated combinationally to give out_data.
- Sample handshake: a sample is accepted when out_valid && out_ready.
  - On acceptance, out_sel toggles.
  - If out_sel was 1, the pair is popped: read pointer advances and count decrements.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- When count = 0, out_data is held at 0 and out_sel is held at 0.
- Scaling: s = sample >>> shift, arithmetic, sign-extended.
  - If shift ≥ IN_W, s = 0 for non-negative samples and s = −1 for negative samples.
- Saturation:
  - s > 2^(OUT_W−1)−1 gives 2^(OUT_W−1)−1.
  - s < −2^(OUT_W−1) gives −2^(OUT_W−1).
  - Otherwise out_data = s[OUT_W−1:0].
- Reset, synchronous, takes priority over every other event in the same cycle:
  - count=0, both pointers=0, out_sel=0, drop_cnt=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0.
  - Asserting rst mid-stream discards all stored pairs and any half-consumed pair.
  - FIFO storage contents are not reset.

## Timing
- Pair pushed at edge t into an empty FIFO:
  - out_valid=1 and n1 appears on out_data in the cycle after edge t.
  - Latency is 1 cycle.
- With out_ready held at 1: n1 is output in cycle t+1 and n2 in cycle t+2.
  - Sustained throughput is 1 sample per cycle, which is 1 pair per 2 cycles.
- in_ready updates one cycle after the count changes.
  - A pop at edge t makes in_ready=1 in the cycle after edge t.
- The generator produces 1 pair per cycle, so the steady-state drop rate is about 1 pair in 2 when out_ready stays high.
- shift affects out_data combinationally in the same cycle.

## Structure
- A shared package `noise_pkg` holds:
  - default IN_W/OUT_W;
  - the saturation bounds;
  - a function `sat_shift(sample, shift)` that performs the arithmetic shift and clamp.
- One sub-module: `pair_fifo`, parameterised by DEPTH and a data width of 2·IN_W.
  - It contains the storage, pointers and count.
  - It provides full/empty flags and push/pop ports.
- The top level holds:
  - the out_sel half-select register;
  - the drop counter;
  - the shift/saturate datapath.

## Test plan
- Reset, then a single push of n1=0x0000_1234, n2=0xFFFF_FF00, with shift=0 and out_ready=1:
  - out_data is 0x1234 with out_sel=0, then 0xFF00 with out_sel=1;
  - out_valid=0 after that;
  - drop_cnt stays 0.
- Saturation with n1=0x7FFF_FFFF, n2=0x8000_0000:
  - shift=0 gives 0x7FFF then 0x8000;
  - shift=16 gives 0x7FFF then 0x8000;
  - shift=31 gives 0x0000 then 0xFFFF.
- Fill and overflow: out_ready=0 with 6 consecutive valid pairs.
  - in_ready falls after the 4th pair;
  - drop_cnt reaches 2;
  - releasing out_ready yields the 4 stored pairs in order, 8 samples.
- Back-to-back traffic: in_valid=1 every cycle and out_ready=1 for 100 cycles.
  - Every accepted pair emerges intact, n1 before n2;
  - drop_cnt equals the number of cycles in which in_ready was 0.
- Backpressure mid-pair: out_ready is deasserted after n1 is accepted.
  - out_data holds n2 with out_sel=1 until out_ready rises;
  - no pop happens early.
- Reset mid-operation: rst pulses with 3 pairs stored and out_sel=1.
  - The next cycle shows out_valid=0, in_ready=1, drop_cnt=0;
  - the next pushed pair is output starting from n1.
